// File: rtl/led.sv
// LED logic function y = ~b & (a | ~c), its registered copy, a saturating
// count of registered rising edges, and a blink divider gated by y_q.
module led #(
    parameter int BLINK_DIV = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             blink
);

    localparam logic [7:0] DIV_LAST = 8'(BLINK_DIV - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             armed_q, armed_d;
    logic             y_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic             blink_q, blink_d;

    assign y = ~b & (a | ~c);

    // armed_q stays low through the first edge after reset release, so that
    // edge neither loads y_q nor counts a rising event.
    always_comb begin
        armed_d    = 1'b1;
        y_d        = y_q;
        rise_cnt_d = rise_cnt_q;
        div_cnt_d  = div_cnt_q;
        blink_d    = blink_q;
        if (!reset) begin
            armed_d    = 1'b0;
            y_d        = 1'b0;
            rise_cnt_d = '0;
            div_cnt_d  = '0;
            blink_d    = 1'b0;
        end else if (armed_q) begin
            y_d = y;
            if (y && !y_q) begin
                rise_cnt_d = sat_inc(rise_cnt_q);
            end
            if (!y_q) begin
                div_cnt_d = '0;
                blink_d   = 1'b0;
            end else if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                blink_d   = ~blink_q;
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        armed_q    <= armed_d;
        y_q        <= y_d;
        rise_cnt_q <= rise_cnt_d;
        div_cnt_q  <= div_cnt_d;
        blink_q    <= blink_d;
    end

    assign rise_cnt = rise_cnt_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_led.sv
// Directed bench for led: one instance with BLINK_DIV=4/CNT_W=8 and one with
// BLINK_DIV=1/CNT_W=2, both driven from the same a/b/c/reset.
module tb_led;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0;
    logic       y_m, yq_m, blink_m;
    logic [7:0] rc_m;
    logic       y_s, yq_s, blink_s;
    logic [1:0] rc_s;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] tt = 8'b0011_0001;

    always #5 clk = ~clk;

    led #(.BLINK_DIV(4), .CNT_W(8)) dut_m (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
        .y(y_m), .y_q(yq_m), .rise_cnt(rc_m), .blink(blink_m)
    );

    led #(.BLINK_DIV(1), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
        .y(y_s), .y_q(yq_s), .rise_cnt(rc_s), .blink(blink_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_abc(input logic [2:0] v);
        {a, b, c} = v;
    endtask

    task automatic do_reset();
        set_abc(3'b010);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        // Reset state, with y still live during reset
        set_abc(3'b000);
        cyc();
        cyc();
        chk("rst_yq_m", yq_m, 0);
        chk("rst_rc_m", rc_m, 0);
        chk("rst_blink_m", blink_m, 0);
        chk("rst_yq_s", yq_s, 0);
        chk("rst_rc_s", rc_s, 0);
        chk("rst_blink_s", blink_s, 0);
        chk("rst_y_live", y_m, 1);

        // Release edge with y=1 must not load y_q nor count
        reset = 1'b1;
        cyc();
        chk("rel_yq", yq_m, 0);
        chk("rel_rc", rc_m, 0);

        // Exhaustive truth table, y checked at the falling edge
        for (int i = 0; i < 8; i++) begin
            set_abc(3'(i));
            @(negedge clk);
            chk($sformatf("tt_y_%0d", i), y_m, tt[i]);
            chk($sformatf("tt_ys_%0d", i), y_s, tt[i]);
            cyc();
            chk($sformatf("tt_yq_%0d", i), yq_m, tt[i]);
        end
        chk("tt_rc_m", rc_m, 2);
        chk("tt_rc_s", rc_s, 2);

        // Registered path
        do_reset();
        set_abc(3'b100);
        cyc();
        chk("reg_yq_rise", yq_m, 1);
        chk("reg_rc", rc_m, 1);
        chk("div1_blink_e1", blink_s, 0);
        cyc();
        chk("div1_blink_e2", blink_s, 1);
        cyc();
        chk("div1_blink_e3", blink_s, 0);
        chk("reg_yq_hold", yq_m, 1);
        set_abc(3'b010);
        cyc();
        chk("reg_yq_fall", yq_m, 0);
        chk("reg_rc_final", rc_m, 1);

        // Blink divider, held for 22 edges to end mid-period with blink=1
        do_reset();
        set_abc(3'b000);
        for (int k = 1; k <= 22; k++) begin
            cyc();
            chk($sformatf("blink4_e%0d", k), blink_m, ((k - 1) / 4) % 2);
            chk($sformatf("blink1_e%0d", k), blink_s, (k - 1) % 2);
        end
        chk("blink_yq_on", yq_m, 1);
        set_abc(3'b011);
        cyc();
        chk("blink_yq_fall", yq_m, 0);
        cyc();
        chk("blink4_forced0", blink_m, 0);
        chk("blink1_forced0", blink_s, 0);
        chk("blink_rc", rc_m, 1);

        // Saturation on the CNT_W=2 instance
        do_reset();
        for (int p = 1; p <= 10; p++) begin
            set_abc(3'b000);
            cyc();
            chk($sformatf("sat_rc_s_%0d", p), rc_s, (p > 3) ? 3 : p);
            chk($sformatf("sat_rc_m_%0d", p), rc_m, p);
            set_abc(3'b010);
            cyc();
        end

        // Reset mid-operation
        do_reset();
        set_abc(3'b000);
        cyc();
        set_abc(3'b010);
        cyc();
        set_abc(3'b000);
        cyc();
        repeat (4) cyc();
        chk("mid_pre_yq", yq_m, 1);
        chk("mid_pre_blink", blink_m, 1);
        chk("mid_pre_rc", rc_m, 2);
        reset = 1'b0;
        set_abc(3'b101);
        cyc();
        chk("mid_yq", yq_m, 0);
        chk("mid_blink", blink_m, 0);
        chk("mid_rc", rc_m, 0);
        chk("mid_yq_s", yq_s, 0);
        chk("mid_blink_s", blink_s, 0);
        chk("mid_rc_s", rc_s, 0);
        chk("mid_y_101", y_m, 1);
        set_abc(3'b011);
        #1;
        chk("mid_y_011", y_m, 0);
        reset = 1'b1;
        set_abc(3'b100);
        cyc();
        chk("post_rel_rc", rc_m, 0);
        chk("post_rel_yq", yq_m, 0);
        cyc();
        chk("post_rc", rc_m, 1);
        chk("post_yq", yq_m, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
